// File: rtl/c2_cfg_pkg.sv
// c2_cfg_pkg: shared states and constants for the C2 configuration loader
package c2_cfg_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, LOAD, PARITY, DONE, ERR} state_t;
  localparam logic [7:0] SYNC_WORD = 8'hA5;
  localparam int CELL_W = 4;
  localparam int D00 = 0;
  localparam int D01 = 1;
  localparam int D10 = 2;
  localparam int D11 = 3;
endpackage

// File: rtl/c2_sync_detect.sv
// c2_sync_detect: 8-bit serial window that flags the sync word including the bit being shifted in
module c2_sync_detect
  import c2_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic match_o
);
  logic [7:0] win_q;
  logic [7:0] win_d;
  assign win_d = {win_q[6:0], bit_i};
  assign match_o = en_i && (win_d == SYNC_WORD);
  always_ff @(posedge clk or posedge rst)
    if (rst) win_q <= '0;
    else if (clr_i) win_q <= '0;
    else if (en_i) win_q <= win_d;
endmodule

// File: rtl/c2_cfg_loader.sv
// c2_cfg_loader: hunts a sync word, shifts in a parity-protected row of C2 cell
// configuration and commits it atomically to the parallel bus
module c2_cfg_loader
  import c2_cfg_pkg::*;
#(
  parameter int NCELLS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  output logic                     ser_ready,
  output logic [CELL_W*NCELLS-1:0] cfg_out,
  output logic                     cfg_valid,
  output logic                     error,
  output logic                     busy
);
  localparam int PW = CELL_W * NCELLS;
  localparam int CW = $clog2(PW + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] shadow_q, cfg_q;
  logic par_q, ready_q, busy_q, valid_q, err_q;
  logic acc, match, sync_clr;
  assign acc = ser_valid && ready_q;
  assign sync_clr = (state_q != SYNC) || abort || match;
  c2_sync_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sync_clr),
    .en_i   (acc && state_q == SYNC),
    .bit_i  (ser_in),
    .match_o(match)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SYNC : IDLE;
      SYNC:    state_d = match ? LOAD : SYNC;
      LOAD:    state_d = (acc && cnt_q == CW'(PW - 1)) ? PARITY : LOAD;
      PARITY:  state_d = !acc ? PARITY : (par_q ^ ser_in) ? ERR : DONE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      par_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d inside {SYNC, LOAD, PARITY};
      busy_q  <= state_d inside {SYNC, LOAD, PARITY};
      valid_q <= state_d == DONE;
      err_q   <= state_d == ERR;
      // each frame starts from a clean shadow, so payload bits can simply be OR-ed in
      if (state_q == IDLE) begin
        cnt_q    <= '0;
        shadow_q <= '0;
        par_q    <= 1'b0;
      end else if (state_q == LOAD && acc) begin
        cnt_q    <= cnt_q + 1'b1;
        shadow_q <= shadow_q | ({{(PW-1){1'b0}}, ser_in} << cnt_q);
        par_q    <= par_q ^ ser_in;
      end
      if (state_d == DONE) cfg_q <= shadow_q;
    end
  assign ser_ready = ready_q;
  assign busy      = busy_q;
  assign cfg_valid = valid_q;
  assign error     = err_q;
  assign cfg_out   = cfg_q;
endmodule

// File: tb/tb_c2_cfg_loader.sv
// tb_c2_cfg_loader: directed frames against a queue-based model of the loader (NCELLS=2)
module tb_c2_cfg_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, ser_in = 0, ser_valid = 0;
  logic ser_ready, cfg_valid, error, busy;
  logic [7:0] cfg_out;
  int checks = 0, errors = 0, cyc_n = 0;
  int vld_n = 0, err_n = 0, vld_cyc = 0, first_cyc = 0;
  logic vld_busy = 1'b1;

  c2_cfg_loader #(.NCELLS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ser_in(ser_in),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .cfg_out(cfg_out),
    .cfg_valid(cfg_valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 hunting, 2 payload, 3 parity bit, 4 committed, 5 rejected
  int ph = 0;
  logic [7:0] win = 0, m_cfg = 0;
  bit pay[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; win = 0; m_cfg = 0; pay.delete();
    end else begin
      automatic bit got = ser_valid && ph >= 1 && ph <= 3;
      if (abort) ph = 0;
      else if (ph == 0) begin
        if (start) begin ph = 1; win = 0; pay.delete(); end
      end else if (ph == 1) begin
        if (got) begin
          win = {win[6:0], ser_in};
          if (win == 8'hA5) ph = 2;
        end
      end else if (ph == 2) begin
        if (got) begin
          pay.push_back(ser_in);
          if (pay.size() == 8) ph = 3;
        end
      end else if (ph == 3) begin
        if (got) begin
          automatic int ones = int'(ser_in);
          foreach (pay[i]) ones += int'(pay[i]);
          if (ones % 2 == 0) begin
            foreach (pay[i]) m_cfg[i] = pay[i];
            ph = 4;
          end else ph = 5;
        end
      end else ph = 0;
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("ser_ready", 32'(ser_ready), 32'(ph >= 1 && ph <= 3));
    chk("busy", 32'(busy), 32'(ph >= 1 && ph <= 3));
    chk("cfg_valid", 32'(cfg_valid), 32'(ph == 4));
    chk("error", 32'(error), 32'(ph == 5));
    chk("cfg_out", 32'(cfg_out), 32'(m_cfg));
    if (cfg_valid) begin vld_n++; vld_cyc = cyc_n; vld_busy = busy; end
    if (error) err_n++;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      ser_in = v[i]; ser_valid = 1; cyc();
      repeat (gap) begin ser_valid = 0; cyc(); end
    end
  endtask

  task automatic begin_load();
    start = 1; cyc(); start = 0;
  endtask

  task automatic frame(input logic [7:0] pl, input logic par, input int gap, input bit noise);
    begin_load();
    first_cyc = cyc_n;
    if (noise) send(32'b110, 3, gap);
    send(32'hA5, 8, gap);
    send(32'(pl), 8, gap);
    send(32'(par), 1, gap);
    ser_valid = 0;
    repeat (3) cyc();
  endtask

  initial begin
    int v0, e0;
    repeat (2) cyc();
    chk("reset cfg_out", 32'(cfg_out), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ser_ready", 32'(ser_ready), 0);
    rst = 0;
    cyc();
    v0 = vld_n; e0 = err_n;
    frame(8'b10010110, 1'b0, 0, 0);
    chk("t1 pulses", 32'(vld_n - v0), 1);
    chk("t1 latency", 32'(vld_cyc - first_cyc), 17);
    chk("t1 cfg", 32'(cfg_out), 32'h69);
    chk("t1 no error", 32'(err_n - e0), 0);
    v0 = vld_n; e0 = err_n;
    frame(8'b10010110, 1'b1, 0, 0);
    chk("t2 error pulses", 32'(err_n - e0), 1);
    chk("t2 no valid", 32'(vld_n - v0), 0);
    chk("t2 cfg kept", 32'(cfg_out), 32'h69);
    v0 = vld_n;
    frame(8'b10010110, 1'b0, 1, 1);
    chk("t3 pulses", 32'(vld_n - v0), 1);
    chk("t3 cfg", 32'(cfg_out), 32'h69);
    chk("t3 busy in done", 32'(vld_busy), 0);
    v0 = vld_n; e0 = err_n;
    begin_load();
    send(32'hA5, 8, 0);
    send(32'b101, 3, 0);
    abort = 1; cyc(); abort = 0; ser_valid = 0;
    repeat (3) cyc();
    chk("t4 abort no valid", 32'(vld_n - v0), 0);
    chk("t4 abort no error", 32'(err_n - e0), 0);
    chk("t4 abort busy", 32'(busy), 0);
    frame(8'hFF, 1'b0, 0, 0);
    chk("t4 cfg ff", 32'(cfg_out), 32'hFF);
    begin_load();
    send(32'hA5, 8, 0);
    send(32'b110, 3, 0);
    #3 rst = 1;
    #1;
    chk("t5 rst cfg", 32'(cfg_out), 0);
    chk("t5 rst busy", 32'(busy), 0);
    chk("t5 rst ready", 32'(ser_ready), 0);
    chk("t5 rst flags", 32'({cfg_valid, error}), 0);
    ser_valid = 0;
    cyc(); rst = 0; cyc();
    frame(8'b10010110, 1'b0, 0, 0);
    chk("t5 reload cfg", 32'(cfg_out), 32'h69);
    frame(8'b10100101, 1'b0, 0, 0);
    chk("t6 cfg", 32'(cfg_out), 32'hA5);
    chk("t6 cell0", 32'(cfg_out[3:0]), 32'b0101);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
